// File: rtl/axi_master_port_pkg.sv
// Shared AXI master-port package: the bus ID width helper, the
// outstanding-count type and the count update rule used on both directions.
package axi_master_port_pkg;

    typedef logic [3:0] out_cnt_t;

    // Bus-side ID width: the master-local ID plus the master-index prefix.
    function automatic int bus_id_w(input int m_id, input int m_width);
        return m_id + m_width;
    endfunction

    // Next outstanding count. A simultaneous increment and decrement cancel.
    // A decrement at zero is an error and saturates at zero.
    function automatic out_cnt_t cnt_next(input out_cnt_t cnt, input logic inc, input logic dec);
        out_cnt_t res;
        res = cnt;
        if (inc && !dec) begin
            res = cnt + 4'd1;
        end else if (dec && !inc && (cnt != 4'd0)) begin
            res = cnt - 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_master_port_skid_buf.sv
// Two-entry skid buffer (module axi_skid_buf) for one AW or AR address
// channel. The input ready is a flop and the output side is a FIFO head, so
// nothing on the input side depends combinationally on out_ready_i, and
// one transfer per cycle is sustained while the buffer holds one entry.
module axi_skid_buf #(
    parameter int DW = 34
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic [1:0]    count_o
);

    logic [DW-1:0] mem_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    cnt_q;
    logic [1:0]    cnt_d;
    logic          ready_q;
    logic          push;
    logic          pop;

    assign push        = in_valid_i && ready_q;
    assign pop         = (cnt_q != 2'd0) && out_ready_i;
    assign in_ready_o  = ready_q;
    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign count_o     = cnt_q;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage, pointers and the registered ready; ready resets high so the
    // master-side ready does not toggle on the first edge after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            ready_q  <= 1'b1;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q   <= cnt_d;
            ready_q <= (cnt_d != 2'd2);
        end
    end

endmodule

// File: rtl/axi_master_port.sv
// AXI master port: prefixes AW/AR IDs with this port's index, strips the
// prefix from returned B/R IDs, and limits outstanding writes and reads to
// MAX_OUT each. B and R are pure combinational pass-through.
// Build option AXI_PORT_SKID_EN: adds a 2-entry skid buffer on AW and AR;
// without it AW/AR pass through combinationally.
module axi_master_port
    import axi_master_port_pkg::*;
#(
    parameter int M_ID       = 2,
    parameter int M_WIDTH    = 2,
    parameter int MASTER_IDX = 0,
    parameter int MAX_OUT    = 4
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic [M_ID-1:0]                      m_aw_id,
    input  logic [31:0]                          m_aw_addr,
    input  logic                                 m_aw_valid,
    output logic                                 m_aw_ready,
    input  logic [M_ID-1:0]                      m_ar_id,
    input  logic [31:0]                          m_ar_addr,
    input  logic                                 m_ar_valid,
    output logic                                 m_ar_ready,
    output logic [bus_id_w(M_ID, M_WIDTH)-1:0]   bus_aw_id,
    output logic [31:0]                          bus_aw_addr,
    output logic                                 bus_aw_valid,
    input  logic                                 bus_aw_ready,
    output logic [bus_id_w(M_ID, M_WIDTH)-1:0]   bus_ar_id,
    output logic [31:0]                          bus_ar_addr,
    output logic                                 bus_ar_valid,
    input  logic                                 bus_ar_ready,
    input  logic [bus_id_w(M_ID, M_WIDTH)-1:0]   bus_b_id,
    input  logic                                 bus_b_valid,
    output logic                                 bus_b_ready,
    input  logic [bus_id_w(M_ID, M_WIDTH)-1:0]   bus_r_id,
    input  logic                                 bus_r_valid,
    output logic                                 bus_r_ready,
    input  logic                                 bus_r_last,
    output logic [M_ID-1:0]                      m_b_id,
    output logic                                 m_b_valid,
    input  logic                                 m_b_ready,
    output logic [M_ID-1:0]                      m_r_id,
    output logic                                 m_r_valid,
    input  logic                                 m_r_ready,
    output logic                                 m_r_last,
    output out_cnt_t                             wr_out_cnt,
    output out_cnt_t                             rd_out_cnt
);

    localparam int                BW      = bus_id_w(M_ID, M_WIDTH);
    localparam out_cnt_t          MAX_CNT = out_cnt_t'(MAX_OUT);
    localparam logic [M_WIDTH-1:0] PREFIX = M_WIDTH'(MASTER_IDX);

    out_cnt_t wr_cnt_q;
    out_cnt_t wr_cnt_d;
    out_cnt_t rd_cnt_q;
    out_cnt_t rd_cnt_d;
    logic     wr_free;
    logic     rd_free;
    logic     wr_inc;
    logic     wr_dec;
    logic     rd_inc;
    logic     rd_dec;

    // Returned channels: zero latency. Valids are held low during reset.
    assign m_b_valid   = rstn && bus_b_valid;
    assign bus_b_ready = m_b_ready;
    assign m_b_id      = bus_b_id[M_ID-1:0];
    assign m_r_valid   = rstn && bus_r_valid;
    assign bus_r_ready = m_r_ready;
    assign m_r_id      = bus_r_id[M_ID-1:0];
    assign m_r_last    = bus_r_last;

`ifdef AXI_PORT_SKID_EN
    logic [1:0]       aw_buf_cnt;
    logic [1:0]       ar_buf_cnt;
    logic             aw_in_ready;
    logic             ar_in_ready;
    logic [4:0]       wr_pend;
    logic [4:0]       rd_pend;
    logic [M_ID+31:0] aw_out_data;
    logic [M_ID+31:0] ar_out_data;

    // Buffered entries count as outstanding; all terms here are registers.
    assign wr_pend    = {1'b0, wr_cnt_q} + {3'b000, aw_buf_cnt};
    assign rd_pend    = {1'b0, rd_cnt_q} + {3'b000, ar_buf_cnt};
    assign wr_free    = (wr_pend < {1'b0, MAX_CNT});
    assign rd_free    = (rd_pend < {1'b0, MAX_CNT});
    assign m_aw_ready = rstn && aw_in_ready && wr_free;
    assign m_ar_ready = rstn && ar_in_ready && rd_free;

    axi_skid_buf #(.DW(M_ID + 32)) u_aw_skid (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid_i  (m_aw_valid && wr_free),
        .in_ready_o  (aw_in_ready),
        .in_data_i   ({m_aw_id, m_aw_addr}),
        .out_valid_o (bus_aw_valid),
        .out_ready_i (bus_aw_ready),
        .out_data_o  (aw_out_data),
        .count_o     (aw_buf_cnt)
    );

    axi_skid_buf #(.DW(M_ID + 32)) u_ar_skid (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid_i  (m_ar_valid && rd_free),
        .in_ready_o  (ar_in_ready),
        .in_data_i   ({m_ar_id, m_ar_addr}),
        .out_valid_o (bus_ar_valid),
        .out_ready_i (bus_ar_ready),
        .out_data_o  (ar_out_data),
        .count_o     (ar_buf_cnt)
    );

    assign bus_aw_id   = {PREFIX, aw_out_data[M_ID+31:32]};
    assign bus_aw_addr = aw_out_data[31:0];
    assign bus_ar_id   = {PREFIX, ar_out_data[M_ID+31:32]};
    assign bus_ar_addr = ar_out_data[31:0];
`else
    // Pass-through: a full count blocks both the bus valid and master ready.
    assign wr_free      = (wr_cnt_q < MAX_CNT);
    assign rd_free      = (rd_cnt_q < MAX_CNT);
    assign bus_aw_valid = rstn && m_aw_valid && wr_free;
    assign m_aw_ready   = rstn && bus_aw_ready && wr_free;
    assign bus_ar_valid = rstn && m_ar_valid && rd_free;
    assign m_ar_ready   = rstn && bus_ar_ready && rd_free;
    assign bus_aw_id    = {PREFIX, m_aw_id};
    assign bus_aw_addr  = m_aw_addr;
    assign bus_ar_id    = {PREFIX, m_ar_id};
    assign bus_ar_addr  = m_ar_addr;
`endif

    assign wr_inc = bus_aw_valid && bus_aw_ready;
    assign wr_dec = bus_b_valid && bus_b_ready;
    assign rd_inc = bus_ar_valid && bus_ar_ready;
    assign rd_dec = bus_r_valid && bus_r_ready && bus_r_last;

    assign wr_out_cnt = wr_cnt_q;
    assign rd_out_cnt = rd_cnt_q;

    // Next outstanding counts; only the last R beat retires a read.
    always_comb begin
        wr_cnt_d = cnt_next(wr_cnt_q, wr_inc, wr_dec);
        rd_cnt_d = cnt_next(rd_cnt_q, rd_inc, rd_dec);
    end

    // Outstanding counters; reset discards any in-flight bookkeeping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    a_wr_cnt_max: assert property (@(posedge clk) disable iff (!rstn) wr_cnt_q <= MAX_CNT);
    a_rd_cnt_max: assert property (@(posedge clk) disable iff (!rstn) rd_cnt_q <= MAX_CNT);
    // Returned responses are already steered here, so they carry our prefix.
    a_b_prefix: assert property (@(posedge clk) disable iff (!rstn)
        bus_b_valid |-> (bus_b_id[BW-1:M_ID] == PREFIX));
    a_r_prefix: assert property (@(posedge clk) disable iff (!rstn)
        bus_r_valid |-> (bus_r_id[BW-1:M_ID] == PREFIX));

endmodule

// File: tb/tb_axi_master_port.sv
// Bench for axi_master_port (default build, pass-through AW/AR):
// directed vectors, a behavioural outstanding-count model and a per-cycle
// compare on the falling edge.
module tb_axi_master_port;
    import axi_master_port_pkg::*;

    localparam int M_ID       = 2;
    localparam int M_WIDTH    = 2;
    localparam int MASTER_IDX = 2;
    localparam int MAX_OUT    = 4;
    localparam int BW         = M_ID + M_WIDTH;

    logic            clk;
    logic            rstn;
    logic [M_ID-1:0] m_aw_id, m_ar_id;
    logic [31:0]     m_aw_addr, m_ar_addr;
    logic            m_aw_valid, m_ar_valid;
    logic            m_aw_ready, m_ar_ready;
    logic [BW-1:0]   bus_aw_id, bus_ar_id;
    logic [31:0]     bus_aw_addr, bus_ar_addr;
    logic            bus_aw_valid, bus_ar_valid;
    logic            bus_aw_ready, bus_ar_ready;
    logic [BW-1:0]   bus_b_id, bus_r_id;
    logic            bus_b_valid, bus_r_valid;
    logic            bus_b_ready, bus_r_ready;
    logic            bus_r_last;
    logic [M_ID-1:0] m_b_id, m_r_id;
    logic            m_b_valid, m_r_valid;
    logic            m_b_ready, m_r_ready;
    logic            m_r_last;
    out_cnt_t        wr_out_cnt, rd_out_cnt;

    int total = 0;
    int bad   = 0;
    int wcnt  = 0;
    int rcnt  = 0;

    axi_master_port #(
        .M_ID(M_ID), .M_WIDTH(M_WIDTH), .MASTER_IDX(MASTER_IDX), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .rstn(rstn),
        .m_aw_id(m_aw_id), .m_aw_addr(m_aw_addr), .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
        .m_ar_id(m_ar_id), .m_ar_addr(m_ar_addr), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
        .bus_aw_id(bus_aw_id), .bus_aw_addr(bus_aw_addr), .bus_aw_valid(bus_aw_valid), .bus_aw_ready(bus_aw_ready),
        .bus_ar_id(bus_ar_id), .bus_ar_addr(bus_ar_addr), .bus_ar_valid(bus_ar_valid), .bus_ar_ready(bus_ar_ready),
        .bus_b_id(bus_b_id), .bus_b_valid(bus_b_valid), .bus_b_ready(bus_b_ready),
        .bus_r_id(bus_r_id), .bus_r_valid(bus_r_valid), .bus_r_ready(bus_r_ready), .bus_r_last(bus_r_last),
        .m_b_id(m_b_id), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
        .m_r_id(m_r_id), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_last(m_r_last),
        .wr_out_cnt(wr_out_cnt), .rd_out_cnt(rd_out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Model: counts move by accepted requests minus retired responses, never below 0.
    always @(posedge clk or negedge rstn) begin
        int wi, wd, ri, rd;
        if (!rstn) begin
            wcnt = 0;
            rcnt = 0;
        end else begin
            wi = (m_aw_valid && bus_aw_ready && wcnt < MAX_OUT) ? 1 : 0;
            wd = (bus_b_valid && m_b_ready) ? 1 : 0;
            ri = (m_ar_valid && bus_ar_ready && rcnt < MAX_OUT) ? 1 : 0;
            rd = (bus_r_valid && m_r_ready && bus_r_last) ? 1 : 0;
            wcnt = wcnt + wi - wd;
            rcnt = rcnt + ri - rd;
            if (wcnt < 0) wcnt = 0;
            if (rcnt < 0) rcnt = 0;
        end
    end

    // Every cycle: compare all outputs with what the model says they must be.
    always @(negedge clk) begin
        int r;
        r = rstn ? 1 : 0;
        chk("cmp_wr_cnt", 32'(wr_out_cnt), wcnt);
        chk("cmp_rd_cnt", 32'(rd_out_cnt), rcnt);
        chk("cmp_bus_aw_valid", 32'(bus_aw_valid), (r == 1 && m_aw_valid && wcnt < MAX_OUT) ? 1 : 0);
        chk("cmp_m_aw_ready", 32'(m_aw_ready), (r == 1 && bus_aw_ready && wcnt < MAX_OUT) ? 1 : 0);
        chk("cmp_bus_ar_valid", 32'(bus_ar_valid), (r == 1 && m_ar_valid && rcnt < MAX_OUT) ? 1 : 0);
        chk("cmp_m_ar_ready", 32'(m_ar_ready), (r == 1 && bus_ar_ready && rcnt < MAX_OUT) ? 1 : 0);
        chk("cmp_bus_aw_id", 32'(bus_aw_id), MASTER_IDX * 4 + int'(m_aw_id));
        chk("cmp_bus_ar_id", 32'(bus_ar_id), MASTER_IDX * 4 + int'(m_ar_id));
        chk("cmp_bus_aw_addr", bus_aw_addr, m_aw_addr);
        chk("cmp_bus_ar_addr", bus_ar_addr, m_ar_addr);
        chk("cmp_m_b_valid", 32'(m_b_valid), (r == 1 && bus_b_valid) ? 1 : 0);
        chk("cmp_m_r_valid", 32'(m_r_valid), (r == 1 && bus_r_valid) ? 1 : 0);
        chk("cmp_bus_b_ready", 32'(bus_b_ready), 32'(m_b_ready));
        chk("cmp_bus_r_ready", 32'(bus_r_ready), 32'(m_r_ready));
        chk("cmp_m_b_id", 32'(m_b_id), int'(bus_b_id) % 4);
        chk("cmp_m_r_id", 32'(m_r_id), int'(bus_r_id) % 4);
        chk("cmp_m_r_last", 32'(m_r_last), 32'(bus_r_last));
    end

    initial begin
        rstn = 1'b0;
        m_aw_id = '0; m_aw_addr = 32'h1000; m_aw_valid = 1'b1;
        m_ar_id = '0; m_ar_addr = 32'h2000; m_ar_valid = 1'b0;
        bus_aw_ready = 1'b0; bus_ar_ready = 1'b0;
        bus_b_id = 4'b1000; bus_b_valid = 1'b1; m_b_ready = 1'b0;
        bus_r_id = 4'b1011; bus_r_valid = 1'b0; m_r_ready = 1'b0; bus_r_last = 1'b0;

        // Reset state, with master valids asserted to show they are masked.
        repeat (2) cyc();
        chk("rst_wr_cnt", 32'(wr_out_cnt), 32'd0);
        chk("rst_rd_cnt", 32'(rd_out_cnt), 32'd0);
        chk("rst_bus_aw_valid", 32'(bus_aw_valid), 32'd0);
        chk("rst_m_b_valid", 32'(m_b_valid), 32'd0);
        m_aw_valid = 1'b0; bus_b_valid = 1'b0;
        cyc();
        rstn = 1'b1;
        #1 chk("rel_bus_aw_valid", 32'(bus_aw_valid), 32'd0);
        cyc();
        chk("rel_edge_wr_cnt", 32'(wr_out_cnt), 32'd0);
        chk("rel_edge_m_aw_ready", 32'(m_aw_ready), 32'd0);

        // ID prefix both ways.
        m_aw_id = 2'd1; m_aw_valid = 1'b1; bus_b_id = 4'b1001;
        #1;
        chk("prefix_bus_aw_id", 32'(bus_aw_id), 32'h9);
        chk("prefix_bus_aw_valid", 32'(bus_aw_valid), 32'd1);
        chk("strip_m_b_id", 32'(m_b_id), 32'h1);
        cyc();

        // Five back-to-back AWs, no B: only four accepted.
        bus_aw_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_aw_id = 2'(i);
            m_aw_addr = 32'h1000 + 32'(i * 16);
            cyc();
        end
        chk("limit_wr_cnt", 32'(wr_out_cnt), 32'd4);
        chk("limit_m_aw_ready", 32'(m_aw_ready), 32'd0);
        chk("limit_bus_aw_valid", 32'(bus_aw_valid), 32'd0);
        cyc();
        chk("limit_hold_wr_cnt", 32'(wr_out_cnt), 32'd4);

        // One B frees a slot; the fifth AW goes through the next cycle.
        bus_b_valid = 1'b1; m_b_ready = 1'b1; bus_b_id = 4'b1000;
        #1;
        chk("release_same_cycle_ready", 32'(m_aw_ready), 32'd0);
        chk("release_m_b_valid", 32'(m_b_valid), 32'd1);
        cyc();
        bus_b_valid = 1'b0;
        #1;
        chk("release_wr_cnt_3", 32'(wr_out_cnt), 32'd3);
        chk("release_next_ready", 32'(m_aw_ready), 32'd1);
        cyc();
        chk("release_wr_cnt_4", 32'(wr_out_cnt), 32'd4);
        chk("release_full_again", 32'(m_aw_ready), 32'd0);

        // Drain writes, then one extra B at zero must not underflow.
        m_aw_valid = 1'b0; bus_aw_ready = 1'b0; bus_b_valid = 1'b1;
        repeat (4) cyc();
        chk("drain_wr_cnt", 32'(wr_out_cnt), 32'd0);
        cyc();
        chk("underflow_wr_cnt", 32'(wr_out_cnt), 32'd0);
        bus_b_valid = 1'b0;

        // Read burst of four beats retires on the last beat only.
        m_ar_valid = 1'b1; bus_ar_ready = 1'b1; m_ar_id = 2'd3; m_ar_addr = 32'h2000;
        #1;
        chk("ar_prefix_id", 32'(bus_ar_id), 32'hB);
        chk("ar_addr", bus_ar_addr, 32'h2000);
        cyc();
        m_ar_valid = 1'b0;
        bus_r_valid = 1'b1; m_r_ready = 1'b1; bus_r_id = 4'b1011;
        for (int b = 0; b < 4; b++) begin
            bus_r_last = (b == 3);
            #1;
            chk("burst_rd_cnt_hold", 32'(rd_out_cnt), 32'd1);
            chk("burst_m_r_id", 32'(m_r_id), 32'h3);
            cyc();
        end
        bus_r_valid = 1'b0; bus_r_last = 1'b0;
        chk("burst_rd_cnt_done", 32'(rd_out_cnt), 32'd0);

        // AR handshake and final R beat in the same cycle at count 2.
        m_ar_valid = 1'b1; m_ar_id = 2'd2;
        repeat (2) cyc();
        chk("simul_rd_cnt_pre", 32'(rd_out_cnt), 32'd2);
        bus_r_valid = 1'b1; bus_r_last = 1'b1;
        cyc();
        chk("simul_rd_cnt_same", 32'(rd_out_cnt), 32'd2);
        m_ar_valid = 1'b0;
        repeat (2) cyc();
        chk("simul_rd_cnt_drain", 32'(rd_out_cnt), 32'd0);
        bus_r_valid = 1'b0; bus_r_last = 1'b0;

        // Simultaneous AW and AR handshakes.
        m_aw_valid = 1'b1; bus_aw_ready = 1'b1; m_aw_id = 2'd0; m_aw_addr = 32'h3000;
        m_ar_valid = 1'b1; m_ar_id = 2'd1; m_ar_addr = 32'h4000;
        #1;
        chk("both_m_aw_ready", 32'(m_aw_ready), 32'd1);
        chk("both_m_ar_ready", 32'(m_ar_ready), 32'd1);
        cyc();
        m_ar_valid = 1'b0;
        chk("both_wr_cnt", 32'(wr_out_cnt), 32'd1);
        chk("both_rd_cnt", 32'(rd_out_cnt), 32'd1);

        // Mid-operation reset with wr_out_cnt=3 and a pending bus AW.
        repeat (2) cyc();
        bus_aw_ready = 1'b0;
        #1;
        chk("midrst_pre_wr_cnt", 32'(wr_out_cnt), 32'd3);
        chk("midrst_pre_valid", 32'(bus_aw_valid), 32'd1);
        rstn = 1'b0;
        #1;
        chk("midrst_wr_cnt", 32'(wr_out_cnt), 32'd0);
        chk("midrst_rd_cnt", 32'(rd_out_cnt), 32'd0);
        chk("midrst_bus_aw_valid", 32'(bus_aw_valid), 32'd0);
        m_aw_valid = 1'b0;
        cyc();
        rstn = 1'b1;
        #1 chk("midrst_rel_valid", 32'(bus_aw_valid), 32'd0);
        cyc();
        chk("midrst_edge_valid", 32'(bus_aw_valid), 32'd0);
        chk("midrst_edge_wr_cnt", 32'(wr_out_cnt), 32'd0);

        repeat (3) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_master_port.md
AXI_MASTER_PORT -- requirements
Module: axi_master_port

Interface
REQ-001 SHALL have the following parameters, one per line as name, default, meaning:
- M_ID, 2, width of the master-local transaction ID.
- M_WIDTH, 2, width of the master-index prefix.
- MASTER_IDX, 0, index of this port, range 0..2**M_WIDTH-1.
- MAX_OUT, 4, maximum outstanding transactions per direction, range 1..15.

REQ-002 SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- m_aw_id / m_ar_id  in  M_ID  master-side AW/AR ID.
- m_aw_addr / m_ar_addr  in  32  master-side AW/AR address.
- m_aw_valid / m_ar_valid  in  1  master-side AW/AR valid.
- m_aw_ready / m_ar_ready  out  1  master-side AW/AR ready.
- bus_aw_id / bus_ar_id  out  M_ID+M_WIDTH  bus-side ID, MASTER_IDX prefix in the upper M_WIDTH bits.
- bus_aw_addr / bus_ar_addr  out  32  bus-side address.
- bus_aw_valid / bus_ar_valid  out  1  bus-side valid, to the master arbiter.
- bus_aw_ready / bus_ar_ready  in  1  bus-side ready.
- bus_b_id / bus_r_id  in  M_ID+M_WIDTH  returned B/R ID.
- bus_b_valid / bus_r_valid  in  1  returned B/R valid, already steered to this port.
- bus_b_ready / bus_r_ready  out  1  returned B/R ready.
- bus_r_last  in  1  last beat of a read burst.
- m_b_id / m_r_id  out  M_ID  B/R ID with the prefix stripped.
- m_b_valid / m_r_valid  out  1  master-side B/R valid.
- m_b_ready / m_r_ready  in  1  master-side B/R ready.
- m_r_last  out  1  forwarded bus_r_last.
- wr_out_cnt / rd_out_cnt  out  4  current outstanding write/read count.

Function
REQ-003 SHALL drive bus_ax_id = {MASTER_IDX[M_WIDTH-1:0], m_ax_id}, and m_b_id / m_r_id = the low M_ID bits of the returned ID.
REQ-004 SHALL pass the B and R channels combinationally: valid, ready, last and ID, with zero latency.
REQ-005 SHALL increment wr_out_cnt on each AW bus handshake (bus_aw_valid && bus_aw_ready).
REQ-006 SHALL decrement wr_out_cnt on each B handshake.
REQ-007 SHALL increment rd_out_cnt on each AR bus handshake.
REQ-008 SHALL decrement rd_out_cnt on each R handshake with bus_r_last=1; non-last beats SHALL not change the count.
REQ-009 SHALL leave a count unchanged when its increment and decrement occur in the same cycle.
REQ-010 SHALL block new AW acceptance when wr_out_cnt==MAX_OUT: deassert m_aw_ready and do not issue new bus_aw_valid. The same rule SHALL apply to AR with rd_out_cnt.
REQ-011 SHALL, when a decrement frees a slot in cycle N, allow acceptance no earlier than cycle N+1 (registered count, no combinational ready path).
REQ-012 SHALL treat a count underflow (decrement at 0) as an error: the count saturates at 0.
REQ-013 SHALL treat a count overflow as unreachable; a simulation assertion SHALL fire if a count ever exceeds MAX_OUT.
REQ-014 SHALL, once bus_ax_valid is asserted, hold it and bus_ax_id/addr stable until bus_ax_ready, because the arbiter locks on valid.
REQ-015 SHALL process AW and AR independently, including simultaneous handshakes on both.

Reset
REQ-016 SHALL, while rstn=0, drive both counts to 0, all valid outputs to 0, and all skid buffers empty.
REQ-017 SHALL, when reset is asserted mid-burst, discard in-flight state; there is no replay.
REQ-018 SHALL deassert reset with no output transition on the first clk edge after release.

Configuration
REQ-019 SHALL, with AXI_PORT_SKID_EN defined, place a 2-entry skid buffer on each of AW and AR: bus_ax_valid follows a master handshake by 1 cycle, m_ax_ready is registered, and full throughput (1 transfer/cycle) is sustained. Outstanding limiting SHALL count entries already buffered as outstanding.
REQ-020 SHALL, without AXI_PORT_SKID_EN, pass AW and AR through combinationally: bus_ax_valid = m_ax_valid && slot_free, and m_ax_ready = bus_ax_ready && slot_free.

Structure
REQ-021 SHALL place the ID-prefix width function and the outstanding-count type in the shared AXI package.
REQ-022 SHALL implement the skid buffer as sub-module axi_skid_buf, instantiated twice (AW, AR), and only when AXI_PORT_SKID_EN is defined.

Verification
REQ-023 SHALL cover ID prefix: MASTER_IDX=2, m_aw_id=1 -> bus_aw_id=4'b1001; bus_b_id=4'b1001 -> m_b_id=2'b01.
REQ-024 SHALL cover the write limit: MAX_OUT=4, 5 AWs issued back-to-back with no B -> 4 accepted, m_aw_ready=0, wr_out_cnt=4.
REQ-025 SHALL cover slot release: one B accepted at cycle N -> 5th AW accepted at cycle N+1 or later, wr_out_cnt returns to 4.
REQ-026 SHALL cover the read burst: AR with 4 R beats -> rd_out_cnt stays 1 until the last beat, then 0.
REQ-027 SHALL cover simultaneous events: AR handshake and final R handshake in the same cycle at rd_out_cnt=2 -> count stays 2.
REQ-028 SHALL cover mid-operation reset: rstn pulsed low with wr_out_cnt=3 and bus_aw_valid=1 -> the count reads 0 and bus_aw_valid=0 immediately, with no glitch on release.
